// File: rtl/timer_arb_pkg.sv
// ---------------------------------------------------------------------------
// timer_arb_pkg
//   Shared definitions for the timer peripheral-bus arbiter:
//     - FSM state encoding (IDLE/GRANT/RELEASE/ERR)
//     - master index constants
//     - values driven onto the slave bus when nobody owns it
//     - round-robin pick helper
//   ERR is only reachable when the design is built with ARB_TIMEOUT_EN.
// ---------------------------------------------------------------------------
package timer_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2,
    ST_ERR     = 2'd3
  } arb_state_e;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam logic [7:0]  IDLE_ADDR = 8'h00;
  localparam logic [15:0] IDLE_DATA = 16'h0000;
  localparam logic        IDLE_RW   = 1'b1;

  // On a tie the master that was not served last wins; otherwise the only
  // requester wins. Callers only use the result when at least one requests.
  function automatic logic pick_master(input logic req0, input logic req1,
                                       input logic last);
    if (req0 && req1) begin
      return ~last;
    end else if (req1) begin
      return M1;
    end else begin
      return M0;
    end
  endfunction

endpackage

// File: rtl/arb_timeout_counter.sv
// ---------------------------------------------------------------------------
// arb_timeout_counter
//   Counts stalled GRANT cycles and flags the cycle in which the count
//   reaches the limit, so the arbiter can leave GRANT on that edge.
//   Only instantiated when ARB_TIMEOUT_EN is defined.
// Ports:
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset (count -> 0)
//   clear    in   force count to 0 (arbiter not in GRANT)
//   enable   in   one more stalled cycle (strobes high, no ack)
//   limit    in   16-bit terminal count
//   expired  out  this enabled cycle brings the count to limit
// ---------------------------------------------------------------------------
module arb_timeout_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [15:0] limit,
  output logic        expired
);

  logic [15:0] count_q;
  logic [15:0] count_d;
  logic [15:0] count_inc;

  assign count_inc = count_q + 16'd1;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = count_inc;
    end
  end

  // Flag on the increment that lands on the limit, so the limit-th stalled
  // cycle is the last one spent in GRANT.
  assign expired = enable && !clear && (count_inc == limit);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/timer_bus_arbiter.sv
// ---------------------------------------------------------------------------
// timer_bus_arbiter
//   Shares the 16-bit 68k-style timer register bus between master 0 (CPU)
//   and master 1 (debug/DMA). Round-robin on ties, grant held through the
//   whole strobe/ack handshake including the ack-release phase.
//   Build option: define ARB_TIMEOUT_EN to add a watchdog that ends a
//   transfer with berr after TIMEOUT_CYCLES stalled cycles.
// Ports:
//   clk, reset                         clock / async active-high reset
//   mN_addr, mN_data_write             master address / write data
//   mN_uds, mN_lds, mN_rw              master byte strobes / direction
//   mN_data_read, mN_ack, mN_berr      per-master responses
//   s_addr, s_data_write, s_uds,
//   s_lds, s_rw                        slave-side bus (muxed)
//   s_data_read, s_ack                 slave responses
// ---------------------------------------------------------------------------
module timer_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  m0_addr,
  input  logic [15:0] m0_data_write,
  input  logic        m0_uds,
  input  logic        m0_lds,
  input  logic        m0_rw,
  output logic [15:0] m0_data_read,
  output logic        m0_ack,
  output logic        m0_berr,
  input  logic [7:0]  m1_addr,
  input  logic [15:0] m1_data_write,
  input  logic        m1_uds,
  input  logic        m1_lds,
  input  logic        m1_rw,
  output logic [15:0] m1_data_read,
  output logic        m1_ack,
  output logic        m1_berr,
  output logic [7:0]  s_addr,
  output logic [15:0] s_data_write,
  output logic        s_uds,
  output logic        s_lds,
  output logic        s_rw,
  input  logic [15:0] s_data_read,
  input  logic        s_ack
);

  import timer_arb_pkg::*;

  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  arb_state_e state_q;
  logic       gnt_q;
  logic       last_q;

  logic req0;
  logic req1;
  logic gnt_req;
  logic in_grant;

  assign req0     = m0_uds | m0_lds;
  assign req1     = m1_uds | m1_lds;
  assign gnt_req  = (gnt_q == M1) ? req1 : req0;
  assign in_grant = (state_q == ST_GRANT);

`ifdef ARB_TIMEOUT_EN
  logic timeout_hit;

  arb_timeout_counter u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q != ST_GRANT),
    .enable  (in_grant && gnt_req && !s_ack),
    .limit   (TIMEOUT_LIMIT),
    .expired (timeout_hit)
  );
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_LIMIT;
`endif

  // Arbitration FSM. The grant only moves from IDLE, and IDLE is only
  // re-entered once s_ack has fallen, so ownership never changes while the
  // slave is still acknowledging.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      gnt_q   <= M0;
      last_q  <= M1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req0 || req1) begin
            gnt_q   <= pick_master(req0, req1, last_q);
            state_q <= ST_GRANT;
          end
        end
        ST_GRANT: begin
          // Strobes low covers both normal completion and an abort.
          if (!gnt_req) begin
            state_q <= ST_RELEASE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (timeout_hit) begin
            state_q <= ST_ERR;
          end
`endif
        end
        ST_RELEASE: begin
          if (!s_ack) begin
            state_q <= ST_IDLE;
            last_q  <= gnt_q;
          end
        end
`ifdef ARB_TIMEOUT_EN
        ST_ERR: begin
          if (!gnt_req) begin
            state_q <= ST_IDLE;
            last_q  <= gnt_q;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Slave bus follows the granted master only in GRANT; every other state
  // (including ERR) parks it at the idle values.
  always_comb begin
    s_addr       = IDLE_ADDR;
    s_data_write = IDLE_DATA;
    s_uds        = 1'b0;
    s_lds        = 1'b0;
    s_rw         = IDLE_RW;
    if (in_grant) begin
      if (gnt_q == M1) begin
        s_addr       = m1_addr;
        s_data_write = m1_data_write;
        s_uds        = m1_uds;
        s_lds        = m1_lds;
        s_rw         = m1_rw;
      end else begin
        s_addr       = m0_addr;
        s_data_write = m0_data_write;
        s_uds        = m0_uds;
        s_lds        = m0_lds;
        s_rw         = m0_rw;
      end
    end
  end

  // Ack and read data pass straight through to the owner.
  assign m0_ack       = in_grant && (gnt_q == M0) && s_ack;
  assign m1_ack       = in_grant && (gnt_q == M1) && s_ack;
  assign m0_data_read = (in_grant && (gnt_q == M0)) ? s_data_read : 16'h0000;
  assign m1_data_read = (in_grant && (gnt_q == M1)) ? s_data_read : 16'h0000;

`ifdef ARB_TIMEOUT_EN
  assign m0_berr = (state_q == ST_ERR) && (gnt_q == M0);
  assign m1_berr = (state_q == ST_ERR) && (gnt_q == M1);
`else
  assign m0_berr = 1'b0;
  assign m1_berr = 1'b0;
`endif

endmodule

// File: tb/tb_timer_bus_arbiter.sv
// Testbench for timer_bus_arbiter: table of per-cycle vectors plus hand-written
// reset and timeout sequences. Inputs change on the falling edge; outputs are
// checked 1 time unit later, i.e. they reflect the current state and inputs.
module tb_timer_bus_arbiter;

  logic        clk;
  logic        reset;
  logic [7:0]  m0_addr, m1_addr;
  logic [15:0] m0_data_write, m1_data_write;
  logic        m0_uds, m0_lds, m0_rw, m1_uds, m1_lds, m1_rw;
  logic [15:0] m0_data_read, m1_data_read;
  logic        m0_ack, m1_ack, m0_berr, m1_berr;
  logic [7:0]  s_addr;
  logic [15:0] s_data_write;
  logic        s_uds, s_lds, s_rw;
  logic [15:0] s_data_read;
  logic        s_ack;

  timer_bus_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .m0_addr      (m0_addr),
    .m0_data_write(m0_data_write),
    .m0_uds       (m0_uds),
    .m0_lds       (m0_lds),
    .m0_rw        (m0_rw),
    .m0_data_read (m0_data_read),
    .m0_ack       (m0_ack),
    .m0_berr      (m0_berr),
    .m1_addr      (m1_addr),
    .m1_data_write(m1_data_write),
    .m1_uds       (m1_uds),
    .m1_lds       (m1_lds),
    .m1_rw        (m1_rw),
    .m1_data_read (m1_data_read),
    .m1_ack       (m1_ack),
    .m1_berr      (m1_berr),
    .s_addr       (s_addr),
    .s_data_write (s_data_write),
    .s_uds        (s_uds),
    .s_lds        (s_lds),
    .s_rw         (s_rw),
    .s_data_read  (s_data_read),
    .s_ack        (s_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0;
    logic        rw0;
    logic [7:0]  a0;
    logic [15:0] d0;
    logic        r1;
    logic        rw1;
    logic [7:0]  a1;
    logic [15:0] d1;
    logic        sack;
    logic [15:0] srd;
    logic        e_stb;
    logic [7:0]  e_addr;
    logic        e_rw;
    logic [15:0] e_wd;
    logic        e_ack0;
    logic        e_ack1;
    logic [15:0] e_rd0;
    logic [15:0] e_rd1;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic r0, input logic rw0, input logic [7:0] a0, input logic [15:0] d0,
                     input logic r1, input logic rw1, input logic [7:0] a1, input logic [15:0] d1,
                     input logic sack, input logic [15:0] srd,
                     input logic e_stb, input logic [7:0] e_addr, input logic e_rw, input logic [15:0] e_wd,
                     input logic e_ack0, input logic e_ack1, input logic [15:0] e_rd0, input logic [15:0] e_rd1);
    vec_t v;
    v.r0 = r0; v.rw0 = rw0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.rw1 = rw1; v.a1 = a1; v.d1 = d1;
    v.sack = sack; v.srd = srd;
    v.e_stb = e_stb; v.e_addr = e_addr; v.e_rw = e_rw; v.e_wd = e_wd;
    v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
    vecs.push_back(v);
  endtask

  // Vector where the arbiter owns nothing: idle slave bus, no responses.
  task automatic add_idle(input logic r0, input logic rw0, input logic [7:0] a0, input logic [15:0] d0,
                          input logic r1, input logic rw1, input logic [7:0] a1, input logic [15:0] d1,
                          input logic sack, input logic [15:0] srd);
    add(r0, rw0, a0, d0, r1, rw1, a1, d1, sack, srd,
        1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000);
  endtask

  task automatic drive(input logic r0, input logic rw0, input logic [7:0] a0, input logic [15:0] d0,
                       input logic r1, input logic rw1, input logic [7:0] a1, input logic [15:0] d1,
                       input logic sack, input logic [15:0] srd);
    m0_uds = r0; m0_lds = r0; m0_rw = rw0; m0_addr = a0; m0_data_write = d0;
    m1_uds = r1; m1_lds = r1; m1_rw = rw1; m1_addr = a1; m1_data_write = d1;
    s_ack = sack; s_data_read = srd;
  endtask

  task automatic check_bus(input string tag, input logic e_stb, input logic [7:0] e_addr,
                           input logic e_rw, input logic [15:0] e_wd, input logic e_ack0,
                           input logic e_ack1, input logic [15:0] e_rd0, input logic [15:0] e_rd1,
                           input logic e_berr0, input logic e_berr1);
    chk({tag, ".s_uds"}, 32'(s_uds), 32'(e_stb));
    chk({tag, ".s_lds"}, 32'(s_lds), 32'(e_stb));
    chk({tag, ".s_addr"}, 32'(s_addr), 32'(e_addr));
    chk({tag, ".s_rw"}, 32'(s_rw), 32'(e_rw));
    chk({tag, ".s_data_write"}, 32'(s_data_write), 32'(e_wd));
    chk({tag, ".m0_ack"}, 32'(m0_ack), 32'(e_ack0));
    chk({tag, ".m1_ack"}, 32'(m1_ack), 32'(e_ack1));
    chk({tag, ".m0_data_read"}, 32'(m0_data_read), 32'(e_rd0));
    chk({tag, ".m1_data_read"}, 32'(m1_data_read), 32'(e_rd1));
    chk({tag, ".m0_berr"}, 32'(m0_berr), 32'(e_berr0));
    chk({tag, ".m1_berr"}, 32'(m1_berr), 32'(e_berr1));
  endtask

  task automatic check_idle(input string tag);
    check_bus(tag, 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  initial begin
    // ---------------- vector table ----------------
    // Tie round-robin: last=1 after reset, expected order M0, M1, M0, M1.
    add_idle(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 0,16'h0000);
    add(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 1,16'h5555, 1,8'h02,0,16'hAAAA, 1,0,16'h5555,16'h0000);
    add(0,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 1,16'h5555, 0,8'h02,0,16'hAAAA, 1,0,16'h5555,16'h0000);
    add_idle(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 1,16'h5555);
    add_idle(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 0,16'h0000);
    add_idle(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 0,16'h0000);
    add(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 1,16'h6666, 1,8'h04,1,16'hBBBB, 0,1,16'h0000,16'h6666);
    add(1,0,8'h02,16'hAAAA, 0,1,8'h04,16'hBBBB, 1,16'h6666, 0,8'h04,1,16'hBBBB, 0,1,16'h0000,16'h6666);
    add_idle(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 0,16'h0000);
    add_idle(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 0,16'h0000);
    add(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 1,16'h7777, 1,8'h02,0,16'hAAAA, 1,0,16'h7777,16'h0000);
    add(0,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 1,16'h7777, 0,8'h02,0,16'hAAAA, 1,0,16'h7777,16'h0000);
    add_idle(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 0,16'h0000);
    add_idle(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 0,16'h0000);
    add(1,0,8'h02,16'hAAAA, 1,1,8'h04,16'hBBBB, 1,16'h8888, 1,8'h04,1,16'hBBBB, 0,1,16'h0000,16'h8888);
    add(0,0,8'h02,16'hAAAA, 0,1,8'h04,16'hBBBB, 1,16'h8888, 0,8'h04,1,16'hBBBB, 0,1,16'h0000,16'h8888);
    add_idle(0,0,8'h00,16'h0000, 0,1,8'h00,16'h0000, 0,16'h0000);
    // Single master: write 0x0100 to addr 6, then read it back.
    add_idle(1,0,8'h06,16'h0100, 0,1,8'h00,16'h0000, 0,16'h0000);
    add(1,0,8'h06,16'h0100, 0,1,8'h00,16'h0000, 0,16'h0000, 1,8'h06,0,16'h0100, 0,0,16'h0000,16'h0000);
    add(1,0,8'h06,16'h0100, 0,1,8'h00,16'h0000, 1,16'h0000, 1,8'h06,0,16'h0100, 1,0,16'h0000,16'h0000);
    add(0,0,8'h06,16'h0100, 0,1,8'h00,16'h0000, 1,16'h0000, 0,8'h06,0,16'h0100, 1,0,16'h0000,16'h0000);
    add_idle(0,0,8'h06,16'h0100, 0,1,8'h00,16'h0000, 0,16'h0000);
    add_idle(1,1,8'h06,16'h0000, 0,1,8'h00,16'h0000, 0,16'h0000);
    add(1,1,8'h06,16'h0000, 0,1,8'h00,16'h0000, 1,16'h0100, 1,8'h06,1,16'h0000, 1,0,16'h0100,16'h0000);
    add(0,1,8'h06,16'h0000, 0,1,8'h00,16'h0000, 1,16'h0100, 0,8'h06,1,16'h0000, 1,0,16'h0100,16'h0000);
    add_idle(0,1,8'h06,16'h0000, 0,1,8'h00,16'h0000, 1,16'h0100);
    add_idle(0,1,8'h06,16'h0000, 0,1,8'h00,16'h0000, 0,16'h0000);
    // Contention: M1 requests while M0 holds the bus with s_ack high 10 cycles.
    add_idle(1,0,8'h08,16'h1111, 0,1,8'h0A,16'h2222, 0,16'h0000);
    add(1,0,8'h08,16'h1111, 1,1,8'h0A,16'h2222, 1,16'h0000, 1,8'h08,0,16'h1111, 1,0,16'h0000,16'h0000);
    add(0,0,8'h08,16'h1111, 1,1,8'h0A,16'h2222, 1,16'h0000, 0,8'h08,0,16'h1111, 1,0,16'h0000,16'h0000);
    for (int k = 0; k < 8; k++) begin
      add_idle(0,0,8'h08,16'h1111, 1,1,8'h0A,16'h2222, 1,16'h0000);
    end
    add_idle(0,0,8'h08,16'h1111, 1,1,8'h0A,16'h2222, 0,16'h0000);
    add_idle(0,0,8'h08,16'h1111, 1,1,8'h0A,16'h2222, 0,16'h0000);
    add(0,0,8'h08,16'h1111, 1,1,8'h0A,16'h2222, 0,16'h3333, 1,8'h0A,1,16'h2222, 0,0,16'h0000,16'h3333);
    add(0,0,8'h08,16'h1111, 1,1,8'h0A,16'h2222, 1,16'h3333, 1,8'h0A,1,16'h2222, 0,1,16'h0000,16'h3333);
    add(0,0,8'h08,16'h1111, 0,1,8'h0A,16'h2222, 1,16'h3333, 0,8'h0A,1,16'h2222, 0,1,16'h0000,16'h3333);
    add_idle(0,0,8'h00,16'h0000, 0,1,8'h00,16'h0000, 0,16'h0000);
    // Abort: M0 drops strobes before any ack; then a tie must go to M1 (last=0).
    add_idle(1,1,8'h0C,16'h0000, 0,1,8'h0E,16'h0000, 0,16'h0000);
    add(1,1,8'h0C,16'h0000, 0,1,8'h0E,16'h0000, 0,16'h0ABC, 1,8'h0C,1,16'h0000, 0,0,16'h0ABC,16'h0000);
    add(0,1,8'h0C,16'h0000, 0,1,8'h0E,16'h0000, 0,16'h0ABC, 0,8'h0C,1,16'h0000, 0,0,16'h0ABC,16'h0000);
    add_idle(0,1,8'h0C,16'h0000, 0,1,8'h0E,16'h0000, 0,16'h0000);
    add_idle(1,1,8'h0C,16'h0000, 1,1,8'h0E,16'h0000, 0,16'h0000);
    add(1,1,8'h0C,16'h0000, 1,1,8'h0E,16'h0000, 0,16'h0000, 1,8'h0E,1,16'h0000, 0,0,16'h0000,16'h0000);
    add(0,1,8'h0C,16'h0000, 0,1,8'h0E,16'h0000, 0,16'h0000, 0,8'h0E,1,16'h0000, 0,0,16'h0000,16'h0000);
    add_idle(0,1,8'h00,16'h0000, 0,1,8'h00,16'h0000, 0,16'h0000);

    // ---------------- reset sequence ----------------
    reset = 1'b1;
    drive(0,1,8'h00,16'h0000, 0,1,8'h00,16'h0000, 0,16'h0000);
    #1;
    check_idle("reset_state");
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    drive(1,0,8'h12,16'h4321, 0,1,8'h00,16'h0000, 0,16'h0000);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("pre_reset.s_uds", 32'(s_uds), 32'd1);
    chk("pre_reset.m0_ack", 32'(m0_ack), 32'd1);
    // Asynchronous reset mid-transfer: outputs idle within the same cycle.
    reset = 1'b1;
    #1;
    check_idle("reset_mid");
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      m1_uds = 1'b1; m1_lds = 1'b1; m1_addr = 8'h34;
      #1;
      check_idle($sformatf("reset_hold%0d", k));
    end
    @(negedge clk);
    reset = 1'b0;
    s_ack = 1'b0;
    #1;
    check_idle("reset_release");
    @(negedge clk);
    #1;
    chk("post_reset_tie.s_addr", 32'(s_addr), 32'h12);
    chk("post_reset_tie.s_uds", 32'(s_uds), 32'd1);
    chk("post_reset_tie.m1_ack", 32'(m1_ack), 32'd0);
    drive(0,1,8'h00,16'h0000, 0,1,8'h00,16'h0000, 0,16'h0000);
    repeat (2) @(negedge clk);
    // Restore last=1 so the table starts from a fresh reset.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].r0, vecs[i].rw0, vecs[i].a0, vecs[i].d0,
            vecs[i].r1, vecs[i].rw1, vecs[i].a1, vecs[i].d1,
            vecs[i].sack, vecs[i].srd);
      #1;
      check_bus($sformatf("v%0d", i), vecs[i].e_stb, vecs[i].e_addr, vecs[i].e_rw, vecs[i].e_wd,
                vecs[i].e_ack0, vecs[i].e_ack1, vecs[i].e_rd0, vecs[i].e_rd1, 1'b0, 1'b0);
    end

`ifdef ARB_TIMEOUT_EN
    // ---------------- timeout sequence (limit 8) ----------------
    @(negedge clk);
    drive(1,1,8'h10,16'h0000, 0,1,8'h14,16'h0000, 0,16'h0000);
    #1;
    check_idle("to_idle");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("to_wait%0d.m0_berr", k), 32'(m0_berr), 32'd0);
      chk($sformatf("to_wait%0d.s_uds", k), 32'(s_uds), 32'd1);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      #1;
      check_bus($sformatf("to_err%0d", k), 1'b0, 8'h00, 1'b1, 16'h0000, 1'b0, 1'b0,
                16'h0000, 16'h0000, 1'b1, 1'b0);
    end
    @(negedge clk);
    m0_uds = 1'b0; m0_lds = 1'b0;
    #1;
    chk("to_drop.m0_berr", 32'(m0_berr), 32'd1);
    @(negedge clk);
    #1;
    check_idle("to_back_idle");
    m0_uds = 1'b1; m0_lds = 1'b1; m1_uds = 1'b1; m1_lds = 1'b1;
    @(negedge clk);
    #1;
    chk("to_last.s_addr", 32'(s_addr), 32'h14);
    chk("to_last.s_uds", 32'(s_uds), 32'd1);
    drive(0,1,8'h00,16'h0000, 0,1,8'h00,16'h0000, 0,16'h0000);
    repeat (3) @(negedge clk);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/timer_bus_arbiter.md
# timer_bus_arbiter

Two-master arbiter sharing the 16-bit 68k-style peripheral bus of the timer (timer/compare/control registers) between the CPU bus interface (master 0) and a second requester such as a debug or DMA port (master 1). It grants one master at a time and holds the grant for the whole strobe/ack handshake, including the ack-release phase. Fairness is round-robin. An optional watchdog terminates transactions the slave never acknowledges.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles a granted strobe may wait for `s_ack` before bus error. Range 2..65535. Used only with `ARB_TIMEOUT_EN`.
- `clk` input, 1: single clock, rising edge.
- `reset` input, 1: asynchronous, active-high reset.
- `m0_addr`, `m1_addr` input, 8: register byte address.
- `m0_data_write`, `m1_data_write` input, 16: write data.
- `m0_uds`, `m0_lds`, `m1_uds`, `m1_lds` input, 1 each: byte strobes. Request = `uds | lds`.
- `m0_rw`, `m1_rw` input, 1: 1 = read, 0 = write.
- `m0_data_read`, `m1_data_read` output, 16: read data. Equals `s_data_read` while that master is granted, else 0.
- `m0_ack`, `m1_ack` output, 1: acknowledge.
- `m0_berr`, `m1_berr` output, 1: bus error (timeout).
- `s_addr`, `s_data_write`, `s_uds`, `s_lds`, `s_rw` output, 8/16/1/1/1: slave-side bus.
- `s_data_read` input, 16: slave read data.
- `s_ack` input, 1: slave acknowledge. The slave holds it high until the strobes drop.

## Operation
- **States:**
  - IDLE: no grant.
  - GRANT: `gnt` register selects the master.
  - RELEASE: master strobes are low; waiting for `s_ack` to fall.
  - ERR: timeout. Exists only with the macro.
- **IDLE:**
  - Only one master requesting: grant it.
  - Both requesting: grant the master not served last (`last` pointer).
  - No request: stay in IDLE.
- **GRANT:**
  - `s_*` = granted master's addr/data/rw/strobes, combinationally muxed.
  - Granted master's ack = `s_ack`, its `data_read` = `s_data_read`.
  - The other master sees ack = 0 and berr = 0. Its request stays pending.
- **GRANT → RELEASE:** when the granted master's request is low.
  - This covers both the normal end of a transfer and an abort before ack.
- **RELEASE → IDLE:** when `s_ack` = 0.
  - On this transition, set `last` to the master just served.
  - Grant is never transferred while `s_ack` is high.
- **Idle slave bus:** in IDLE/RELEASE, `s_uds` = `s_lds` = 0, `s_rw` = 1, `s_addr` = 0, `s_data_write` = 0.
- **Reset (any time, including mid-transfer):**
  - State = IDLE, `last` = 1 (master 0 wins the first tie).
  - All ack/berr = 0, all data_read = 0, slave bus in its idle values.
  - Timeout counter = 0.

## Timing
- **Grant latency:** request high at edge N in IDLE → `gnt` registered at N → `s_*` strobes high during cycle N..N+1.
- **Ack path:** master ack follows `s_ack` combinationally, with zero added latency.
- **Minimum occupancy per transfer:** 1 IDLE cycle + GRANT cycles + ≥1 RELEASE cycle.
  - A back-to-back request from the other master is granted at the edge after the return to IDLE.
- **Request dropped and reasserted by the granted master while in RELEASE:** it re-arbitrates normally in IDLE. There is no grant parking.
- **Simultaneous request while the other master is mid-transfer:** held off; no ack, no berr.

## Configuration
- **`ARB_TIMEOUT_EN` defined:**
  - 16-bit counter, cleared on entering GRANT, increments each GRANT cycle with the strobes high and `s_ack` = 0.
  - When count == `TIMEOUT_CYCLES`, go to ERR.
  - In ERR: `s_*` strobes forced 0, and the granted master's berr = 1 (ack = 0) until its request drops.
  - Then go to IDLE and update `last`.
- **`ARB_TIMEOUT_EN` undefined:**
  - No counter and no ERR state.
  - berr outputs tied 0.
  - A slave that never acks stalls the bus indefinitely.

## Structure
- **Shared package `timer_arb_pkg`:**
  - State encoding constants: IDLE = 0, GRANT = 1, RELEASE = 2, ERR = 3.
  - Master index constants M0 = 0, M1 = 1.
  - Idle-bus constants.
- **Sub-module `arb_timeout_counter`:** clear/enable/limit → `expired`. Instantiated only under `ARB_TIMEOUT_EN`.
- **Top level:** FSM, `gnt`/`last` registers and the bus muxes live in `timer_bus_arbiter`.

## Test plan
- **Reset:** assert `reset` for 5 cycles mid-transfer (master 0 strobes high) → all acks/berr 0, `s_uds`/`s_lds` 0, `s_rw` 1 within the same cycle. After release, the first tie goes to master 0.
- **Single master:** master 0 writes 0x0100 to addr 6, then reads addr 6 → `s_addr` = 6 one cycle after request, read returns 0x0100. `m1_ack` stays 0 throughout.
- **Tie round-robin:** both masters request simultaneously for 4 consecutive transfers → grant order 0, 1, 0, 1. No overlap of `s_*` strobes. Each grant starts only after `s_ack` = 0.
- **Contention mid-transfer:** master 1 requests while master 0 is granted with `s_ack` held high 10 cycles → master 1 is granted at the first edge after RELEASE → IDLE.
- **Abort:** master 0 drops strobes before `s_ack` → RELEASE, then IDLE next edge. No ack delivered; `last` = 0.
- **Timeout (`ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8):** slave never acks → `m0_berr` = 1 after 8 cycles, `s_*` strobes 0. `m0_berr` clears and the FSM returns to IDLE when master 0 drops its strobes.
